// File: rtl/led_breather.sv
// LED breathing driver: TICK steps LEVEL through ramp up, hold, ramp down, hold; O is an N-bit PWM of LEVEL.
// Latency: O registered one CLK after the PWM compare; duty re-latched only at PWM wrap (pwm_cnt 2^N-1 -> 0).
// Backpressure: none; EN low or RESET forces IDLE next edge. LED_BREATHER_GAMMA_EN selects a square-law duty.
module led_breather #(
    parameter int N          = 8,
    parameter int HOLD_TICKS = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         TICK,
    input  logic         EN,
    output logic         O,
    output logic [N-1:0] LEVEL,
    output logic [2:0]   STATE
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    localparam int              HW        = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [N-1:0]    LVL_MAX   = '1;
    localparam logic [N-1:0]    LVL_PEN   = {{(N-1){1'b1}}, 1'b0};
    localparam logic [N-1:0]    LVL_ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_TICKS - 1);

    state_t          state;
    logic [HW-1:0]   hold_cnt;
    logic [N-1:0]    pwm_cnt;
    logic [N-1:0]    duty_latched;
    logic [N-1:0]    duty_src;

`ifdef LED_BREATHER_GAMMA_EN
    logic [2*N-1:0]  level_sq;

    // Square-law brightness: keep only the upper half of the 2N-bit product.
    assign level_sq = {{N{1'b0}}, LEVEL} * {{N{1'b0}}, LEVEL};
    assign duty_src = N'(level_sq >> N);
`else
    assign duty_src = LEVEL;
`endif

    assign STATE = state;

    always_ff @(posedge CLK) begin
        if (RESET || !EN) begin
            state        <= IDLE;
            LEVEL        <= '0;
            hold_cnt     <= '0;
            pwm_cnt      <= '0;
            duty_latched <= '0;
            O            <= 1'b0;
        end else begin
            if (state == IDLE) begin
                pwm_cnt      <= '0;
                duty_latched <= '0;
                O            <= 1'b0;
            end else begin
                pwm_cnt <= pwm_cnt + LVL_ONE;
                O       <= (pwm_cnt < duty_latched);
                // Duty only changes at the period boundary so a period is never cut short.
                if (pwm_cnt == LVL_MAX)
                    duty_latched <= duty_src;
            end

            case (state)
                IDLE: begin
                    state    <= UP;
                    LEVEL    <= '0;
                    hold_cnt <= '0;
                end
                UP: begin
                    if (TICK && LEVEL != LVL_MAX) begin
                        LEVEL <= LEVEL + LVL_ONE;
                        if (LEVEL == LVL_PEN) begin
                            state    <= HOLD_HI;
                            hold_cnt <= '0;
                        end
                    end
                end
                HOLD_HI: begin
                    if (TICK) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            state    <= DOWN;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                DOWN: begin
                    if (TICK && LEVEL != '0) begin
                        LEVEL <= LEVEL - LVL_ONE;
                        if (LEVEL == LVL_ONE) begin
                            state    <= HOLD_LO;
                            hold_cnt <= '0;
                        end
                    end
                end
                HOLD_LO: begin
                    if (TICK) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            state    <= UP;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    LEVEL        <= '0;
                    hold_cnt     <= '0;
                    pwm_cnt      <= '0;
                    duty_latched <= '0;
                    O            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_breather.sv
// Scoreboard bench for led_breather at N=4, HOLD_TICKS=2.
module tb_led_breather;

    localparam int N  = 4;
    localparam int HT = 2;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         TICK = 1'b0;
    logic         EN = 1'b1;
    logic         O;
    logic [N-1:0] LEVEL;
    logic [2:0]   STATE;

    int checks = 0;
    int errors = 0;

    // Bench-side view of the PWM phase, derived from the inputs alone.
    logic [N-1:0] ph = '0;
    bit           running = 1'b0;

    int           exp_o_q[$];
    int           exp_st_q[$];

    led_breather #(.N(N), .HOLD_TICKS(HT)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .TICK  (TICK),
        .EN    (EN),
        .O     (O),
        .LEVEL (LEVEL),
        .STATE (STATE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        bit rn;
        rn = !RESET && EN;
        @(posedge CLK);
        if (running && rn) ph = ph + 4'd1;
        else ph = '0;
        running = rn;
        #1;
    endtask

    task automatic tick_once();
        TICK = 1'b1;
        step();
        TICK = 1'b0;
        step();
    endtask

    function automatic int dexp(input int l);
`ifdef LED_BREATHER_GAMMA_EN
        return (l * l) >> N;
`else
        return l;
`endif
    endfunction

    task automatic sync_period();
        step();
        while (ph != '0) step();
    endtask

    // Precondition: ph==0 and the duty for lvl has just been latched.
    task automatic pwm_window(input int lvl, input int tick_at, input string name);
        int d;
        int e;
        d = dexp(lvl);
        for (int k = 0; k < 16; k++) exp_o_q.push_back((k < d) ? 1 : 0);
        for (int k = 0; k < 16; k++) begin
            if (tick_at >= 0 && int'(ph) == tick_at) TICK = 1'b1;
            step();
            TICK = 1'b0;
            e = exp_o_q.pop_front();
            checks++;
            if (O !== 1'(e)) begin
                errors++;
                $display("FAIL %s: cycle %0d O=%b expected %0d", name, k, O, e);
            end
        end
    endtask

    task automatic restart_up();
        RESET = 1'b1;
        EN    = 1'b1;
        TICK  = 1'b0;
        step();
        RESET = 1'b0;
        step();
    endtask

    task automatic test_reset();
        RESET = 1'b1; EN = 1'b1; TICK = 1'b0;
        step();
        checks++;
        if (O !== 1'b0 || LEVEL !== 4'd0 || STATE !== 3'd0) begin
            errors++;
            $display("FAIL reset: O=%b LEVEL=%0d STATE=%0d expected 0/0/0", O, LEVEL, STATE);
        end
        step();
        RESET = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            checks++;
            if (STATE !== 3'd1 || LEVEL !== 4'd0 || O !== 1'b0) begin
                errors++;
                $display("FAIL idle_run[%0d]: STATE=%0d LEVEL=%0d O=%b expected 1/0/0", i, STATE, LEVEL, O);
            end
        end
    endtask

    task automatic test_pwm();
        for (int i = 0; i < 4; i++) tick_once();
        checks++;
        if (LEVEL !== 4'd4) begin
            errors++;
            $display("FAIL pwm_level: LEVEL=%0d expected 4", LEVEL);
        end
        sync_period();
        pwm_window(4, -1, "pwm4_a");
        pwm_window(4, -1, "pwm4_b");
    endtask

    task automatic test_mid_period_tick();
        pwm_window(4, 7, "mid_old");
        checks++;
        if (LEVEL !== 4'd5) begin
            errors++;
            $display("FAIL mid_level: LEVEL=%0d expected 5", LEVEL);
        end
        pwm_window(5, -1, "mid_new");
    endtask

    task automatic test_full_cycle();
        int st, lv, e;
        bit held;
        restart_up();
        for (int i = 0; i < 34; i++) begin
            if (i < 15)      begin st = (i == 14) ? 2 : 1; lv = i + 1; end
            else if (i < 17) begin st = (i == 16) ? 3 : 2; lv = 15; end
            else if (i < 32) begin st = (i == 31) ? 4 : 3; lv = 15 - (i - 16); end
            else             begin st = (i == 33) ? 1 : 4; lv = 0; end
            exp_st_q.push_back(st * 16 + lv);
            // The ramp down uses TICK held high: each high cycle is a tick.
            held = (i >= 17 && i < 31);
            TICK = 1'b1;
            step();
            if (!held) begin
                TICK = 1'b0;
                step();
            end
            e = exp_st_q.pop_front();
            checks++;
            if ({1'b0, STATE, LEVEL} !== 8'(e)) begin
                errors++;
                $display("FAIL cycle_tick[%0d]: STATE=%0d LEVEL=%0d expected %0d/%0d",
                         i, STATE, LEVEL, e / 16, e % 16);
            end
        end
    endtask

    task automatic check_down9(input string name);
        checks++;
        if (STATE !== 3'd3 || LEVEL !== 4'd9) begin
            errors++;
            $display("FAIL %s: STATE=%0d LEVEL=%0d expected 3/9", name, STATE, LEVEL);
        end
    endtask

    task automatic test_en_drop();
        restart_up();
        for (int i = 0; i < 23; i++) tick_once();
        check_down9("pre_en_drop");
        while (ph != 4'd2) step();
        EN = 1'b0; TICK = 1'b1;
        step();
        TICK = 1'b0;
        checks++;
        if (STATE !== 3'd0 || LEVEL !== 4'd0 || O !== 1'b0) begin
            errors++;
            $display("FAIL en_drop: STATE=%0d LEVEL=%0d O=%b expected 0/0/0", STATE, LEVEL, O);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (STATE !== 3'd0 || O !== 1'b0) begin
                errors++;
                $display("FAIL en_low_hold[%0d]: STATE=%0d O=%b expected 0/0", i, STATE, O);
            end
        end
        EN = 1'b1;
        step();
        checks++;
        if (STATE !== 3'd1 || LEVEL !== 4'd0) begin
            errors++;
            $display("FAIL en_rise: STATE=%0d LEVEL=%0d expected 1/0", STATE, LEVEL);
        end
        tick_once();
        checks++;
        if (LEVEL !== 4'd1) begin
            errors++;
            $display("FAIL en_rise_tick: LEVEL=%0d expected 1", LEVEL);
        end
        for (int i = 0; i < 22; i++) tick_once();
        check_down9("pre_reset");
        while (ph != 4'd2) step();
        RESET = 1'b1; TICK = 1'b1;
        step();
        RESET = 1'b0; TICK = 1'b0;
        checks++;
        if (STATE !== 3'd0 || LEVEL !== 4'd0 || O !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_down: STATE=%0d LEVEL=%0d O=%b expected 0/0/0", STATE, LEVEL, O);
        end
        step();
        checks++;
        if (STATE !== 3'd1 || LEVEL !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: STATE=%0d LEVEL=%0d expected 1/0", STATE, LEVEL);
        end
    endtask

    task automatic test_duty_source();
        restart_up();
        for (int i = 0; i < 8; i++) tick_once();
        checks++;
        if (LEVEL !== 4'd8) begin
            errors++;
            $display("FAIL duty_l8: LEVEL=%0d expected 8", LEVEL);
        end
        sync_period();
        pwm_window(8, -1, "duty_l8");
        for (int i = 0; i < 7; i++) tick_once();
        checks++;
        if (LEVEL !== 4'd15 || STATE !== 3'd2) begin
            errors++;
            $display("FAIL duty_l15: STATE=%0d LEVEL=%0d expected 2/15", STATE, LEVEL);
        end
        sync_period();
        pwm_window(15, -1, "duty_l15");
        for (int i = 0; i < 14; i++) tick_once();
        checks++;
        if (LEVEL !== 4'd3 || STATE !== 3'd3) begin
            errors++;
            $display("FAIL duty_l3: STATE=%0d LEVEL=%0d expected 3/3", STATE, LEVEL);
        end
        sync_period();
        pwm_window(3, -1, "duty_l3");
    endtask

    initial begin
        test_reset();
        test_pwm();
        test_mid_period_tick();
        test_full_cycle();
        test_en_drop();
        test_duty_source();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
